// File: rtl/nb_cache_noc_interface_pkg.sv
// Shared cache/NoC message encodings, MSHR entry states and the code translation helpers.
package nb_cache_noc_interface_pkg;

  localparam int NO_MSG  = 0;
  localparam int GET_S   = 1;
  localparam int GET_M   = 2;
  localparam int PUT_M   = 3;
  localparam int DATA_S  = 4;
  localparam int DATA_E  = 5;
  localparam int DATA_M  = 6;
  localparam int PUT_ACK = 7;

  localparam int NO_REQ     = 0;
  localparam int R_REQ      = 1;
  localparam int W_REQ      = 2;
  localparam int WB_REQ     = 3;
  localparam int MEM_RESP   = 4;
  localparam int MEM_RESP_S = 5;
  localparam int MEM_RESP_E = 6;
  localparam int MEM_RESP_M = 7;

  typedef enum logic [1:0] {MSHR_FREE, MSHR_SEND, MSHR_WAIT, MSHR_RESP} mshr_state_e;

  function automatic int noc_of_req(input int req);
    case (req)
      R_REQ:   return GET_S;
      W_REQ:   return GET_M;
      WB_REQ:  return PUT_M;
      default: return NO_MSG;
    endcase
  endfunction

  function automatic int resp_of_noc(input int msg);
    case (msg)
      DATA_S:  return MEM_RESP_S;
      DATA_E:  return MEM_RESP_E;
      DATA_M:  return MEM_RESP_M;
      PUT_ACK: return MEM_RESP;
      default: return NO_REQ;
    endcase
  endfunction

  function automatic logic is_resp(input int msg);
    case (msg)
      DATA_S, DATA_E, DATA_M, PUT_ACK: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nb_cache_noc_interface_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, idx, gidx;
  logic          found;

  // N is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + PW'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 ptr <= '0;
    else if (advance && found) ptr <= gidx + PW'(1);
  end

endmodule

// File: rtl/nb_cache_noc_interface.sv
// Non-blocking cache-to-NoC bridge: MSHR tracking of outstanding line requests,
// round-robin NoC issue, address-matched response capture and in-order-by-index delivery.
module nb_cache_noc_interface
  import nb_cache_noc_interface_pkg::*;
#(
  parameter int ADDRESS_BITS      = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int MSG_BITS          = 4,
  parameter int ID_BITS           = 2,
  parameter int DEFAULT_DEST      = 0,
  parameter int MSHR_ENTRIES      = 4,
  localparam int CACHE_WIDTH      = DATA_WIDTH << CACHE_OFFSET_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cache_msg_in,
  input  logic [ADDRESS_BITS-1:0] cache_address_in,
  input  logic [CACHE_WIDTH-1:0]  cache_data_in,
  output logic                    cache_req_ready,
  output logic [MSG_BITS-1:0]     cache_msg_out,
  output logic [ADDRESS_BITS-1:0] cache_address_out,
  output logic [CACHE_WIDTH-1:0]  cache_data_out,
  output logic [MSG_BITS-1:0]     noc_msg_out,
  output logic [ADDRESS_BITS-1:0] noc_address_out,
  output logic [CACHE_WIDTH-1:0]  noc_data_out,
  output logic [ID_BITS-1:0]      noc_dest_id,
  input  logic                    packetizer_busy,
  input  logic [MSG_BITS-1:0]     noc_msg_in,
  input  logic [ADDRESS_BITS-1:0] noc_address_in,
  input  logic [CACHE_WIDTH-1:0]  noc_data_in,
  input  logic [ID_BITS-1:0]      noc_src_id,
  output logic                    mshr_full,
  output logic                    unmatched_err
);
  // Addresses are byte addresses: a line spans the word offset plus the byte-in-word bits.
  localparam int LINE_OFF = CACHE_OFFSET_BITS + $clog2(DATA_WIDTH / 8);
  localparam int IW       = $clog2(MSHR_ENTRIES);
  localparam logic [ADDRESS_BITS-1:0] LINE_MASK =
    ~((ADDRESS_BITS'(1) << LINE_OFF) - ADDRESS_BITS'(1));
  localparam logic [MSG_BITS-1:0] M_NO_MSG = MSG_BITS'(NO_MSG);
  localparam logic [MSG_BITS-1:0] M_NO_REQ = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_WB_REQ = MSG_BITS'(WB_REQ);

  mshr_state_e                                state [MSHR_ENTRIES];
  logic [MSHR_ENTRIES-1:0][ADDRESS_BITS-1:0]  line;
  logic [MSHR_ENTRIES-1:0][MSG_BITS-1:0]      code;
  logic [MSHR_ENTRIES-1:0][CACHE_WIDTH-1:0]   data;

  logic [MSHR_ENTRIES-1:0] free_vec, send_vec, resp_vec, conflict_vec, hit_vec;
  logic [MSHR_ENTRIES-1:0] arb_req, grant, sent_mask;
  logic [IW-1:0]           alloc_idx, hit_idx, deliv_idx, grant_idx, send_idx;
  logic [ADDRESS_BITS-1:0] req_line, rsp_line;
  logic accept, rsp_valid, rsp_hit, deliver, noc_valid, consume, load;
  logic unused_src;

  assign unused_src = ^noc_src_id;
  assign req_line   = cache_address_in & LINE_MASK;
  assign rsp_line   = noc_address_in & LINE_MASK;

  always_comb begin
    free_vec     = '0;
    send_vec     = '0;
    resp_vec     = '0;
    conflict_vec = '0;
    hit_vec      = '0;
    for (int i = 0; i < MSHR_ENTRIES; i++) begin
      free_vec[i]     = state[i] == MSHR_FREE;
      send_vec[i]     = state[i] == MSHR_SEND;
      resp_vec[i]     = state[i] == MSHR_RESP;
      conflict_vec[i] = state[i] != MSHR_FREE && line[i] == req_line;
      hit_vec[i]      = state[i] == MSHR_WAIT && line[i] == rsp_line;
    end
  end

  // Lowest-index pickers; scanning downward leaves the smallest set index.
  always_comb begin
    alloc_idx = '0;
    hit_idx   = '0;
    deliv_idx = '0;
    grant_idx = '0;
    for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IW'(i);
      if (hit_vec[i])  hit_idx   = IW'(i);
      if (resp_vec[i]) deliv_idx = IW'(i);
      if (grant[i])    grant_idx = IW'(i);
    end
  end

  assign cache_req_ready = (|free_vec) && !(|conflict_vec);
  assign mshr_full       = ~|free_vec;
  assign accept          = cache_msg_in != M_NO_REQ && cache_req_ready;
  assign rsp_valid       = is_resp(int'(noc_msg_in));
  assign rsp_hit         = rsp_valid && (|hit_vec);
  assign deliver         = |resp_vec;
  assign noc_valid       = noc_msg_out != M_NO_MSG;
  assign consume         = noc_valid && !packetizer_busy;
  assign load            = !noc_valid || !packetizer_busy;
  assign noc_dest_id     = ID_BITS'(DEFAULT_DEST);

  // The entry being consumed is still SEND pre-edge; keep it out of the next pick.
  assign sent_mask = consume ? (MSHR_ENTRIES'(1) << send_idx) : '0;
  assign arb_req   = send_vec & ~sent_mask;

  rr_arbiter #(.N(MSHR_ENTRIES)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (arb_req),
    .advance (load),
    .grant   (grant)
  );

  // Each event targets an entry in a distinct state, so at most one branch fires per entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSHR_ENTRIES; i++) begin
        state[i] <= MSHR_FREE;
        line[i]  <= '0;
        code[i]  <= '0;
        data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MSHR_ENTRIES; i++) begin
        if (accept && alloc_idx == IW'(i)) begin
          state[i] <= MSHR_SEND;
          line[i]  <= req_line;
          code[i]  <= cache_msg_in;
          data[i]  <= cache_data_in;
        end else if (consume && send_idx == IW'(i)) begin
          state[i] <= MSHR_WAIT;
        end else if (rsp_hit && hit_idx == IW'(i)) begin
          state[i] <= MSHR_RESP;
          code[i]  <= MSG_BITS'(resp_of_noc(int'(noc_msg_in)));
          data[i]  <= noc_data_in;
        end else if (deliver && deliv_idx == IW'(i)) begin
          state[i] <= MSHR_FREE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      noc_msg_out     <= M_NO_MSG;
      noc_address_out <= '0;
      noc_data_out    <= '0;
      send_idx        <= '0;
    end else if (load) begin
      if (|grant) begin
        noc_msg_out     <= MSG_BITS'(noc_of_req(int'(code[grant_idx])));
        noc_address_out <= line[grant_idx];
        noc_data_out    <= (code[grant_idx] == M_WB_REQ) ? data[grant_idx] : '0;
        send_idx        <= grant_idx;
      end else begin
        noc_msg_out     <= M_NO_MSG;
        noc_address_out <= '0;
        noc_data_out    <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_msg_out     <= M_NO_REQ;
      cache_address_out <= '0;
      cache_data_out    <= '0;
      unmatched_err     <= 1'b0;
    end else begin
      if (deliver) begin
        cache_msg_out     <= code[deliv_idx];
        cache_address_out <= line[deliv_idx];
        cache_data_out    <= data[deliv_idx];
      end else begin
        cache_msg_out     <= M_NO_REQ;
        cache_address_out <= '0;
        cache_data_out    <= '0;
      end
      if (rsp_valid && !(|hit_vec)) unmatched_err <= 1'b1;
    end
  end

endmodule
